// File: rtl/pcm_pkg.sv
// pcm_pkg: shared constants and arbiter state type for pcm_mem_arbiter
package pcm_pkg;
  localparam int PCM_NUM_CPU = 4;
  localparam int PCM_MEM_AW = 11;
  localparam int PCM_DW = 16;
  localparam int PCM_CPU_AW = 20;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, HOST} arb_state_t;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: four-way round-robin pick, first requester after i_last wins
//   i_req   : request vector
//   i_last  : index granted most recently
//   o_idx   : chosen index, o_valid when any request is present
module rr_pick4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_last,
  output logic [1:0] o_idx,
  output logic       o_valid
);
  logic [1:0] w_start;
  logic [3:0] w_rot;
  logic [1:0] w_off;
  assign w_start = i_last + 2'd1;
  // rotate so bit 0 is the highest-priority requester
  assign w_rot = 4'({i_req, i_req} >> w_start);
  assign w_off = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
  assign o_idx = w_start + w_off;
  assign o_valid = |i_req;
endmodule

// File: rtl/pcm_mem_arbiter.sv
// pcm_mem_arbiter: round-robin arbiter of four CPUs onto the PCM RAM port, handed to the Nios host during init
//   cpu_*   : per-CPU level request/we/addr/wdata in, one-hot ready pulse and shared read data out
//   host_*  : Nios host port, passed straight to pcm_* while the host owns the RAM
//   pcm_*   : RAM port, read latency 1
//   oor_err : sticky, set by any CPU access beyond the RAM
module pcm_mem_arbiter
  import pcm_pkg::*;
#(
  parameter int NUM_CPU = PCM_NUM_CPU,
  parameter int AW      = PCM_CPU_AW,
  parameter int MEM_AW  = PCM_MEM_AW,
  parameter int DW      = PCM_DW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [NUM_CPU-1:0]    cpu_req,
  input  logic [NUM_CPU-1:0]    cpu_we,
  input  logic [NUM_CPU*AW-1:0] cpu_addr,
  input  logic [NUM_CPU*DW-1:0] cpu_wdata,
  output logic [NUM_CPU-1:0]    cpu_ready,
  output logic [DW-1:0]         cpu_rdata,
  output logic                  oor_err,
  input  logic [MEM_AW-1:0]     host_address,
  input  logic                  host_chipselect,
  input  logic                  host_clken,
  input  logic                  host_write,
  input  logic [DW-1:0]         host_writedata,
  input  logic [1:0]            host_byteenable,
  output logic [DW-1:0]         host_readdata,
  output logic [MEM_AW-1:0]     pcm_address,
  output logic                  pcm_chipselect,
  output logic                  pcm_clken,
  output logic                  pcm_write,
  output logic [DW-1:0]         pcm_writedata,
  output logic [1:0]            pcm_byteenable,
  input  logic [DW-1:0]         pcm_readdata
);
  arb_state_t r_state, w_next;
  logic [1:0] r_grant, r_last, w_pick;
  logic w_valid, w_we, w_oor, r_oor;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata, r_rdata;
  rr_pick4 u_pick (.i_req(cpu_req), .i_last(r_last), .o_idx(w_pick), .o_valid(w_valid));
  assign w_addr = cpu_addr[int'(r_grant)*AW +: AW];
  assign w_wdata = cpu_wdata[int'(r_grant)*DW +: DW];
  assign w_we = cpu_we[r_grant];
  assign w_oor = |w_addr[AW-1:MEM_AW];
  assign cpu_ready = (r_state == DONE) ? NUM_CPU'(1) << r_grant : '0;
  assign cpu_rdata = r_rdata;
  assign oor_err = r_oor;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_grant <= 2'd0;
      r_last <= 2'd3;
      r_rdata <= '0;
      r_oor <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && !init && w_valid) r_grant <= w_pick;
      if (r_state == WAIT && !w_we) r_rdata <= w_oor ? '0 : pcm_readdata;
      if (r_state == WAIT && w_oor) r_oor <= 1'b1;
      if (r_state == DONE) r_last <= r_grant;
    end
  always_comb begin
    w_next = r_state;
    pcm_address = '0;
    pcm_chipselect = 1'b0;
    pcm_clken = 1'b0;
    pcm_write = 1'b0;
    pcm_writedata = '0;
    pcm_byteenable = 2'b00;
    host_readdata = '0;
    case (r_state)
      IDLE:    w_next = init ? HOST : w_valid ? ISSUE : IDLE;
      ISSUE: begin
        w_next = WAIT;
        pcm_address = w_addr[MEM_AW-1:0];
        pcm_chipselect = 1'b1;
        pcm_clken = 1'b1;
        pcm_write = w_we & ~w_oor;
        pcm_writedata = w_wdata;
        pcm_byteenable = 2'b11;
      end
      WAIT:    w_next = DONE;
      DONE:    w_next = IDLE;
      HOST: begin
        w_next = init ? HOST : IDLE;
        pcm_address = host_address;
        pcm_chipselect = host_chipselect;
        pcm_clken = host_clken;
        pcm_write = host_write;
        pcm_writedata = host_writedata;
        pcm_byteenable = host_byteenable;
        host_readdata = pcm_readdata;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_pcm_mem_arbiter.sv
// tb_pcm_mem_arbiter: directed bench with a transaction-level model of the arbiter and a RAM model
module tb_pcm_mem_arbiter;
  logic clk = 0, reset = 0, init = 0;
  logic [3:0] cpu_req = 0, cpu_we = 0;
  logic [79:0] cpu_addr = 0;
  logic [63:0] cpu_wdata = 0;
  logic [3:0] cpu_ready;
  logic [15:0] cpu_rdata;
  logic oor_err;
  logic [10:0] host_address = 0;
  logic host_chipselect = 0, host_clken = 0, host_write = 0;
  logic [15:0] host_writedata = 0;
  logic [1:0] host_byteenable = 0;
  logic [15:0] host_readdata;
  logic [10:0] pcm_address;
  logic pcm_chipselect, pcm_clken, pcm_write;
  logic [15:0] pcm_writedata;
  logic [1:0] pcm_byteenable;
  logic [15:0] pcm_readdata = 0;
  int errs = 0, checks = 0, cyc = 0;
  bit [15:0] ram [2048];
  bit [15:0] m_mem [2048];
  int m_gnt = -1, m_age = 0, m_last = 3;
  bit m_host = 0, m_oor = 0;
  logic [15:0] m_rdata = 0;
  logic [19:0] m_a;
  int q_idx[$], q_cyc[$];
  logic [15:0] q_dat[$];
  bit hold[4];

  pcm_mem_arbiter dut (
    .clk(clk), .reset(reset), .init(init),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .oor_err(oor_err),
    .host_address(host_address), .host_chipselect(host_chipselect), .host_clken(host_clken),
    .host_write(host_write), .host_writedata(host_writedata), .host_byteenable(host_byteenable),
    .host_readdata(host_readdata),
    .pcm_address(pcm_address), .pcm_chipselect(pcm_chipselect), .pcm_clken(pcm_clken),
    .pcm_write(pcm_write), .pcm_writedata(pcm_writedata), .pcm_byteenable(pcm_byteenable),
    .pcm_readdata(pcm_readdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // RAM with one-cycle read latency and byte enables
  always @(posedge clk) if (pcm_chipselect && pcm_clken) begin
    if (pcm_write)
      ram[pcm_address] <= {pcm_byteenable[1] ? pcm_writedata[15:8] : ram[pcm_address][15:8],
                           pcm_byteenable[0] ? pcm_writedata[7:0] : ram[pcm_address][7:0]};
    pcm_readdata <= ram[pcm_address];
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  // Model: one access per grant, counted as 1=issue, 2=wait, 3=ready cycles after the grant decision
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_gnt = -1; m_age = 0; m_last = 3; m_host = 0; m_oor = 0; m_rdata = 0;
    end else if (m_host) begin
      if (host_chipselect && host_clken && host_write) m_mem[host_address] = host_writedata;
      if (!init) m_host = 0;
    end else if (m_gnt < 0) begin
      if (init) m_host = 1;
      else for (int k = 4; k >= 1; k--)
        if (cpu_req[(m_last + k) % 4]) begin m_gnt = (m_last + k) % 4; m_age = 1; end
    end else begin
      m_a = cpu_addr[m_gnt*20 +: 20];
      if (m_age == 1 && cpu_we[m_gnt] && m_a < 2048) m_mem[m_a[10:0]] = cpu_wdata[m_gnt*16 +: 16];
      if (m_age == 2 && !cpu_we[m_gnt]) m_rdata = (m_a < 2048) ? m_mem[m_a[10:0]] : 16'h0000;
      if (m_age == 2 && m_a >= 2048) m_oor = 1;
      if (m_age == 3) begin m_last = m_gnt; m_gnt = -1; end
      m_age++;
    end
  end

  always @(negedge clk) if (reset) begin
    logic [31:0] e_bus;
    logic [19:0] a;
    e_bus = 0;
    if (m_host)
      e_bus = {host_address, host_chipselect, host_clken, host_write, host_writedata, host_byteenable};
    else if (m_gnt >= 0 && m_age == 1) begin
      a = cpu_addr[m_gnt*20 +: 20];
      e_bus = {a[10:0], 2'b11, cpu_we[m_gnt] && a < 2048, cpu_wdata[m_gnt*16 +: 16], 2'b11};
    end
    chk("pcm_bus", {pcm_address, pcm_chipselect, pcm_clken, pcm_write, pcm_writedata, pcm_byteenable}, e_bus);
    chk("cpu_ready", cpu_ready, (m_gnt >= 0 && m_age == 3) ? 4'(1 << m_gnt) : 4'h0);
    chk("cpu_rdata", cpu_rdata, m_rdata);
    chk("oor_err", oor_err, m_oor);
    chk("host_readdata", host_readdata, m_host ? pcm_readdata : 16'h0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 4; i++) if (cpu_ready[i]) begin
      q_idx.push_back(i); q_cyc.push_back(cyc); q_dat.push_back(cpu_rdata);
      if (!hold[i]) cpu_req[i] = 0;
    end
  endtask

  task automatic req(input int i, input bit we, input logic [19:0] a, input logic [15:0] d);
    cpu_we[i] = we; cpu_addr[i*20 +: 20] = a; cpu_wdata[i*16 +: 16] = d; cpu_req[i] = 1;
  endtask

  task automatic wait_rdy(input int i, input int exp_c);
    int base, c, got;
    base = q_idx.size(); c = 0;
    step();
    while (q_idx.size() == base && c < 30) begin c++; step(); end
    got = (q_idx.size() > base) ? q_idx[$] : -1;
    chk($sformatf("ready%0d_latency", i), c, exp_c);
    chk($sformatf("ready%0d_index", i), got, i);
  endtask

  task automatic wait_log(input int n, input int lim);
    int c;
    c = 0;
    while (q_idx.size() < n && c < lim) begin step(); c++; end
    chk("log_count", q_idx.size(), n);
  endtask

  task automatic host_wr(input logic [10:0] a, input logic [15:0] d);
    host_address = a; host_writedata = d; host_byteenable = 2'b11;
    host_chipselect = 1; host_clken = 1; host_write = 1;
    tick(1);
    host_chipselect = 0; host_clken = 0; host_write = 0;
  endtask

  task automatic chk_reset_outputs(input string n);
    chk({n, "_ready"}, cpu_ready, 0);
    chk({n, "_pcm"}, {pcm_address, pcm_chipselect, pcm_clken, pcm_write, pcm_writedata, pcm_byteenable}, 0);
    chk({n, "_rdata"}, cpu_rdata, 0);
    chk({n, "_oor"}, oor_err, 0);
    chk({n, "_host_rd"}, host_readdata, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(2);
    chk_reset_outputs("reset");
    reset = 1;
    tick(1);
    // preload words 0..3 through the host port, then all four CPUs read
    init = 1;
    tick(1);
    for (int i = 0; i < 4; i++) host_wr(11'(i), 16'h1000 + 16'(i));
    init = 0;
    tick(1);
    for (int i = 0; i < 4; i++) req(i, 0, 20'(i), 16'h0);
    wait_log(4, 40);
    for (int i = 0; i < 4; i++) begin
      chk("rr_order", q_idx[i], i);
      chk("rr_data", q_dat[i], 16'h1000 + 16'(i));
      if (i > 0) chk("rr_spacing", q_cyc[i] - q_cyc[i-1], 4);
    end
    tick(1);
    // write then read back
    req(0, 1, 20'h00010, 16'hBEEF);
    wait_rdy(0, 3);
    tick(1);
    chk("wr_ram", ram[16], 16'hBEEF);
    req(0, 0, 20'h00010, 16'h0);
    wait_rdy(0, 3);
    chk("rd_beef", cpu_rdata, 16'hBEEF);
    tick(1);
    // out of range
    req(2, 1, 20'h00800, 16'h1234);
    wait_rdy(2, 3);
    chk("oor_set", oor_err, 1);
    tick(1);
    chk("oor_nowrite", ram[0], 16'h1000);
    req(2, 0, 20'h00800, 16'h0);
    wait_rdy(2, 3);
    chk("oor_rdata", cpu_rdata, 16'h0000);
    chk("oor_sticky", oor_err, 1);
    tick(1);
    // init raised during CPU1's wait cycle
    req(1, 0, 20'h00002, 16'h0);
    tick(2);
    init = 1;
    req(3, 0, 20'h00007, 16'h0);
    wait_rdy(1, 1);
    chk("init_rd", cpu_rdata, 16'h1002);
    tick(2);
    host_wr(11'd7, 16'h5A5A);
    chk("host_wr_ram", ram[7], 16'h5A5A);
    host_address = 11'd7; host_chipselect = 1; host_clken = 1;
    tick(1);
    chk("host_rd", host_readdata, 16'h5A5A);
    chk("host_stall", cpu_ready, 0);
    host_chipselect = 0; host_clken = 0;
    init = 0;
    wait_rdy(3, 4);
    chk("cpu3_rd", cpu_rdata, 16'h5A5A);
    tick(1);
    // reset during CPU0's issue cycle
    req(1, 0, 20'h00003, 16'h0);
    wait_rdy(1, 3);
    tick(1);
    req(0, 1, 20'h00005, 16'hDEAD);
    tick(1);
    reset = 0;
    #1;
    chk_reset_outputs("rst_mid");
    req(0, 0, 20'h00005, 16'h0);
    req(2, 0, 20'h00001, 16'h0);
    tick(2);
    chk("rst_cut_write", ram[5], 16'h0000);
    reset = 1;
    wait_rdy(0, 3);
    chk("rst_rd5", cpu_rdata, 16'h0000);
    wait_rdy(2, 3);
    tick(1);
    // CPU0 and CPU1 keep requesting back to back
    q_idx.delete(); q_cyc.delete(); q_dat.delete();
    hold[0] = 1; hold[1] = 1;
    req(0, 0, 20'h00001, 16'h0);
    req(1, 0, 20'h00002, 16'h0);
    wait_log(4, 40);
    for (int i = 0; i < 4; i++) chk("b2b_order", q_idx[i], i % 2);
    hold[0] = 0; hold[1] = 0;
    cpu_req = 0;
    tick(6);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pcm_mem_arbiter.md
# pcm_mem_arbiter

Shared-memory arbiter between the four PCM worker CPUs and the single on-chip PCM memory port. It grants one CPU word access at a time using round-robin priority and returns read data and a one-cycle ready to the granted CPU. While the PCCM's `init` is high, it hands the memory port to the Nios host. It sits directly downstream of the CPU memory buses and upstream of the PCM RAM.

## Interface
- `NUM_CPU`, 4: number of requesting CPUs; the round-robin logic supports exactly 4.
- `AW`, 20: CPU address width.
- `MEM_AW`, 11: PCM RAM word-address width.
- `DW`, 16: data width.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `init` in 1: PCCM init; while 1, the host owns the memory port.
- `cpu_req` in NUM_CPU: per-CPU access request, level; held until ready.
- `cpu_we` in NUM_CPU: 1 = write, 0 = read; valid with req.
- `cpu_addr` in NUM_CPU×AW: per-CPU word address.
- `cpu_wdata` in NUM_CPU×DW: per-CPU write data.
- `cpu_ready` out NUM_CPU: one-hot, one-cycle completion pulse.
- `cpu_rdata` out DW: shared read-data register; valid while `cpu_ready` is high, held until the next read completes.
- `oor_err` out 1: sticky flag; set on any CPU access with `addr[AW-1:MEM_AW]` ≠ 0.
- `host_address` in MEM_AW, `host_chipselect` in 1, `host_clken` in 1, `host_write` in 1, `host_writedata` in DW, `host_byteenable` in 2: Nios host port.
- `host_readdata` out DW: host read data.
- `pcm_address` out MEM_AW, `pcm_chipselect` out 1, `pcm_clken` out 1, `pcm_write` out 1, `pcm_writedata` out DW, `pcm_byteenable` out 2: RAM port.
- `pcm_readdata` in DW: RAM read data, read latency 1.

## Operation
- States are IDLE, ISSUE, WAIT, DONE and HOST.
- **IDLE**
  - If `init` = 1, go to HOST.
  - Else if any `cpu_req` is set, register `grant` from round-robin order starting at `last+1` mod 4 and go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - Drive `pcm_chipselect` = 1, `pcm_clken` = 1, `pcm_address` = `cpu_addr[grant][MEM_AW-1:0]`, `pcm_byteenable` = 2'b11, `pcm_writedata` = `cpu_wdata[grant]`.
  - `pcm_write` = `cpu_we[grant]`, forced to 0 if the address is out of range.
- **WAIT**
  - For an in-range read, load `cpu_rdata` from `pcm_readdata`.
  - For an out-of-range read, load `cpu_rdata` = 16'h0000.
  - Writes leave `cpu_rdata` unchanged.
  - Out of range sets `oor_err`.
- **DONE**
  - `cpu_ready[grant]` = 1 for this cycle only.
  - Update `last` = `grant`, then go to IDLE.
- **HOST**
  - All `pcm_*` outputs follow the `host_*` inputs combinationally.
  - `host_readdata` = `pcm_readdata`.
  - No CPU is granted.
  - When `init` = 0, go to IDLE.
- **Outside HOST:** `host_readdata` = 0. All `pcm_*` outputs are 0 except in ISSUE and HOST.
- **Init mid-transaction:** if `init` rises in ISSUE, WAIT or DONE, the current access completes normally and HOST is entered via IDLE.
- **Request hold:** a CPU must deassert `cpu_req` in the cycle after its ready. A request still present in IDLE counts as a new request.
- **Ignored inputs:** `cpu_we`, `cpu_addr` and `cpu_wdata` are ignored for non-granted CPUs.

## Timing
- **Reset values:** state = IDLE, `last` = 3 (so CPU0 has first priority), `grant` = 0, `cpu_ready` = 0, `cpu_rdata` = 0, `oor_err` = 0, all `pcm_*` = 0, `host_readdata` = 0.
- **Reset mid-operation:** return to IDLE within the same cycle. The in-flight access is dropped with no ready, and any RAM write in that cycle is cut off.
- **Latency:**
  - Request seen in IDLE at cycle N: ISSUE at N+1, WAIT at N+2, DONE (ready) at N+3.
  - Next grant is decided at N+4.
  - Throughput is one access per 4 cycles.
- **Fairness:** with all four CPUs requesting continuously, grants go 0,1,2,3,0… Worst-case wait for one CPU is 4 accesses (16 cycles).
- **Simultaneous events:** `init` and `cpu_req` rising in the same IDLE cycle go to HOST; the request waits.
- **Leaving HOST:** the first grant after HOST is 1 cycle after `init` falls, plus the normal latency.

## Structure
- **Package `pcm_pkg`:**
  - state enum `arb_state_t`;
  - constants `PCM_NUM_CPU` = 4, `PCM_MEM_AW` = 11, `PCM_DW` = 16, `PCM_CPU_AW` = 20.
- **Sub-module `rr_pick4`:** combinational; inputs are a 4-bit request vector and a 2-bit `last`; outputs are a 2-bit index and `valid`.
- **Top-level instantiation:** `cpu_req` is driven from each CPU's `~Mem_CE`, and `cpu_we` from each CPU's `~Mem_WE` (both active-low).

## Test plan
- **Write then read:** CPU0 writes 16'hBEEF at address 20'h00010, then reads it back. Required: ready[0] 3 cycles after each request; `pcm_write` high only in ISSUE; read `cpu_rdata` = 16'hBEEF.
- **Round-robin:** all four CPUs request reads of addresses 0–3, preloaded with 16'h1000–16'h1003. Required: ready order 0,1,2,3, each 4 cycles apart, and each CPU receives its own word.
- **Out of range:** CPU2 writes to 20'h00800. Required: no `pcm_write`, ready[2] is still pulsed, `oor_err` = 1 and stays set. A following read of 20'h00800 returns 16'h0000.
- **Init during access:** raise `init` during CPU1's WAIT. Required: ready[1] still pulses, then HOST is entered. A host write of 16'h5A5A to address 7 reaches the RAM, and a CPU3 request is stalled until `init` falls.
- **Reset mid-access:** assert `reset` low during ISSUE. Required: all outputs reach their reset values immediately and no ready is issued. After release, the first grant goes to CPU0.
- **Back-to-back requester:** CPU0 holds `cpu_req` continuously while CPU1 also requests. Required: grants alternate 0,1,0,1.
